servo_ramp_sequencer: RTL and testbench
=======================================

SERVO_RAMP_SEQUENCER -- requirements
Module: servo_ramp_sequencer

Interface
REQ-001 The block SHALL have parameter DUTY_RESET, default 32'd75000, the duty value each channel's shadow holds after reset.
REQ-002 The block SHALL have parameter CH_STRIDE, default 12, the byte stride between channel register groups on the PWM bus.
REQ-003 The block SHALL have parameter D_OFFSET, default 4, the byte offset of the duty register within a channel group.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: res  input  1  reset, asynchronous and active-high.
REQ-006 Port: cmd_valid  input  1  move command present.
REQ-007 Port: cmd_ready  output  1  block can accept a command.
REQ-008 Port: cmd_ch  input  3  target servo channel 0-7.
REQ-009 Port: cmd_target  input  32  final duty value.
REQ-010 Port: cmd_step  input  16  duty increment per step; 0 means jump directly to target.
REQ-011 Port: cmd_interval  input  24  clocks between steps; 0 is treated as 1.
REQ-012 Port: cmd_abort  input  1  stop the current move.
REQ-013 Port: bus_wr, bus_rd  output  1 each  PWM register bus write/read strobes.
REQ-014 Port: bus_addr  output  32  PWM register address.
REQ-015 Port: bus_data  output  32  write data.
REQ-016 Port: bus_rdata  input  32  read data, valid the cycle after bus_rd.
REQ-017 Port: busy  output  1  move in progress; done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, RD, RDWAIT, WAIT, STEP, WRITE and DONE; RD and RDWAIT exist only under SEQ_READBACK_EN.
REQ-019 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready; on accept all cmd_* fields are latched and the current value is loaded from shadow[cmd_ch].
REQ-020 If the latched target equals the current value on accept, the FSM SHALL go to DONE without any bus write.
REQ-021 WAIT SHALL count max(interval,1) cycles, then go to STEP.
REQ-022 STEP SHALL compute next = min(cur+step, target) when target > cur, else max(cur-step, target) using 33-bit arithmetic with no wrap; if step = 0, next = target.
REQ-023 WRITE SHALL assert bus_wr for exactly one cycle with bus_addr = ch*CH_STRIDE+D_OFFSET and bus_data = next, and SHALL update cur and shadow[ch] on the same edge.
REQ-024 After WRITE, the FSM SHALL go to DONE if next = target, else to WAIT.
REQ-025 DONE SHALL assert done for one cycle, then return to IDLE; busy = 1 in every state except IDLE.
REQ-026 The first bus_wr SHALL occur max(I,1)+2 cycles after the accept edge (I = interval), and subsequent writes every max(I,1)+2 cycles.
REQ-027 On cmd_abort in WAIT or STEP, the FSM SHALL go to DONE on the next edge with no further write.
REQ-028 On cmd_abort during WRITE, that write SHALL complete, then the FSM goes to DONE; cmd_abort in IDLE SHALL be ignored.
REQ-029 bus_wr and bus_rd SHALL never be asserted together, and bus_addr/bus_data SHALL be 0 when no strobe is active.

Reset
REQ-030 Asserting res SHALL immediately force IDLE, set all eight shadows to DUTY_RESET, and clear all internal counters.
REQ-031 While res is asserted: cmd_ready = 0 and bus_wr = bus_rd = bus_addr = bus_data = busy = done = 0; cmd_ready = 1 on the first clock after res deasserts.
REQ-032 Reset during a move SHALL abandon it with no further bus write and no done pulse.

Configuration
REQ-033 With SEQ_READBACK_EN defined, accept SHALL go to RD, which asserts bus_rd for one cycle at the channel duty address.
REQ-034 With SEQ_READBACK_EN defined, RDWAIT SHALL load bus_rdata into cur and the shadow, then apply REQ-020 and proceed to WAIT; this adds 2 cycles to REQ-026.
REQ-035 Without SEQ_READBACK_EN, bus_rd SHALL be tied 0, bus_rdata SHALL be unused, and cur comes from the shadow.

Verification
REQ-036 Scenario: after reset, send ch=2, target=75300, step=100, interval=4 -> three writes at addr 0x1C with data 75100, 75200, 75300, spaced 6 cycles apart, then one done pulse.
REQ-037 Scenario: ch=0, target=74950, step=100, interval=0 -> a single write of 74950 at addr 0x04 (clamped), then done.
REQ-038 Scenario: ch=7, target=90000, step=0 -> one write at addr 0x58 with data 90000.
REQ-039 Scenario: target equal to shadow (75000) -> no bus_wr, done pulse 1 cycle after accept.
REQ-040 Scenario: cmd_abort mid-ramp after the 2nd write -> no further writes, done pulse, and the next command ramps from the last written value.
REQ-041 Scenario: res pulsed mid-WAIT -> all outputs 0 immediately; afterwards shadows read back as 75000 via a step-0 move; with SEQ_READBACK_EN, bus_rd is asserted at addr ch*12+4 and cur follows bus_rdata.

Source files
------------

// File: rtl/servo_ramp_sequencer.sv
// ============================================================================
// Module      : servo_ramp_sequencer
// Description : Eight-channel servo duty ramp sequencer. Accepts a move
//               command, steps the channel duty toward its target at a fixed
//               interval, and writes each intermediate value to the PWM
//               register bus. A per-channel shadow keeps the last written
//               duty so the next move starts from it.
//               Optional feature macro: SEQ_READBACK_EN -- read the current
//               duty from the PWM bus before ramping instead of using the
//               shadow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_ramp_sequencer #(
  parameter logic [31:0] DUTY_RESET = 32'd75000,
  parameter int unsigned CH_STRIDE  = 12,
  parameter int unsigned D_OFFSET   = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_ch,
  input  logic [31:0] cmd_target,
  input  logic [15:0] cmd_step,
  input  logic [23:0] cmd_interval,
  input  logic        cmd_abort,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef SEQ_READBACK_EN
    RD     = 3'd1,
    RDWAIT = 3'd2,
`endif
    WAIT   = 3'd3,
    STEP   = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Byte address of the duty register for a channel.
  function automatic logic [31:0] duty_addr(input logic [2:0] ch);
    return 32'(ch) * 32'(CH_STRIDE) + 32'(D_OFFSET);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [31:0] target_q, target_d;
  logic [15:0] step_q, step_d;
  logic [23:0] interval_q, interval_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] next_q, next_d;
  logic [31:0] shadow_q [8];
  logic [31:0] shadow_d [8];

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_q, bus_data_d;
`ifdef SEQ_READBACK_EN
  logic        bus_rd_q, bus_rd_d;
`else
  logic        rdata_unused;
`endif

  logic        accept;
  logic [23:0] interval_eff;
  logic [32:0] up_sum;
  logic [32:0] dn_diff;
  logic [31:0] step_next;

  assign accept       = cmd_valid & cmd_ready_q;
  assign interval_eff = (cmd_interval == 24'd0) ? 24'd1 : cmd_interval;

  // Next duty value: one step toward target, clamped at target, 33-bit so
  // neither direction can wrap around.
  always_comb begin
    up_sum  = {1'b0, cur_q} + {17'd0, step_q};
    dn_diff = {1'b0, cur_q} - {17'd0, step_q};
    if (step_q == 16'd0) begin
      step_next = target_q;
    end else if (target_q > cur_q) begin
      step_next = (up_sum > {1'b0, target_q}) ? target_q : up_sum[31:0];
    end else begin
      step_next = (dn_diff[32] || (dn_diff[31:0] < target_q)) ? target_q : dn_diff[31:0];
    end
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    target_d    = target_q;
    step_d      = step_q;
    interval_d  = interval_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    next_d      = next_q;
    shadow_d    = shadow_q;
    done_d      = 1'b0;
    bus_wr_d    = 1'b0;
    bus_addr_d  = 32'd0;
    bus_data_d  = 32'd0;
`ifdef SEQ_READBACK_EN
    bus_rd_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d       = cmd_ch;
          target_d   = cmd_target;
          step_d     = cmd_step;
          interval_d = interval_eff;
          cur_d      = shadow_q[cmd_ch];
`ifdef SEQ_READBACK_EN
          // Read strobe is visible during RD; data returns during RDWAIT.
          state_d    = RD;
          bus_rd_d   = 1'b1;
          bus_addr_d = duty_addr(cmd_ch);
`else
          if (cmd_target == shadow_q[cmd_ch]) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = interval_eff;
          end
`endif
        end
      end
`ifdef SEQ_READBACK_EN
      RD: begin
        state_d = RDWAIT;
      end
      RDWAIT: begin
        cur_d          = bus_rdata;
        shadow_d[ch_q] = bus_rdata;
        if (target_q == bus_rdata) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = interval_q;
        end
      end
`endif
      WAIT: begin
        if (cmd_abort) begin
          state_d = DONE;
          cnt_d   = 24'd0;
        end else if (cnt_q <= 24'd1) begin
          state_d = STEP;
          cnt_d   = 24'd0;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      STEP: begin
        if (cmd_abort) begin
          state_d = DONE;
        end else begin
          next_d  = step_next;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The strobe is registered on the edge leaving WRITE, together with
        // the cur/shadow update, so an abort here still lets it complete.
        bus_wr_d       = 1'b1;
        bus_addr_d     = duty_addr(ch_q);
        bus_data_d     = next_q;
        cur_d          = next_q;
        shadow_d[ch_q] = next_q;
        if ((next_q == target_q) || cmd_abort) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = interval_q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // All state and outputs registered; reset abandons any move immediately.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      ch_q        <= 3'd0;
      target_q    <= 32'd0;
      step_q      <= 16'd0;
      interval_q  <= 24'd0;
      cnt_q       <= 24'd0;
      cur_q       <= 32'd0;
      next_q      <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= DUTY_RESET;
      end
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_data_q  <= 32'd0;
`ifdef SEQ_READBACK_EN
      bus_rd_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      target_q    <= target_d;
      step_q      <= step_d;
      interval_q  <= interval_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      next_q      <= next_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
`ifdef SEQ_READBACK_EN
      bus_rd_q    <= bus_rd_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
`ifdef SEQ_READBACK_EN
  assign bus_rd    = bus_rd_q;
`else
  assign bus_rd       = 1'b0;
  assign rdata_unused = ^bus_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_servo_ramp_sequencer.sv
// ============================================================================
// Module      : tb_servo_ramp_sequencer
// Description : Self-checking bench for servo_ramp_sequencer. A behavioural
//               model derives the expected write sequence, write cycles and
//               done cycle for each move from the duty-ramp rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_ramp_sequencer;

  localparam logic [31:0] DUTY_RST = 32'd75000;
`ifdef SEQ_READBACK_EN
  localparam int RB_EXTRA = 2;
`else
  localparam int RB_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_abort = 1'b0;
  logic [2:0]  cmd_ch = 3'd0;
  logic [31:0] cmd_target = 32'd0;
  logic [15:0] cmd_step = 16'd0;
  logic [23:0] cmd_interval = 24'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        cmd_ready, bus_wr, bus_rd, busy, done;
  logic [31:0] bus_addr, bus_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] shadow_m [8];
  logic [31:0] pwm_m [8];
  logic [31:0] pwm_hw [8] = '{default: 32'd75000};
  logic [2:0]  hw_idx;

  servo_ramp_sequencer #(
    .DUTY_RESET(DUTY_RST),
    .CH_STRIDE (12),
    .D_OFFSET  (4)
  ) dut (
    .clk         (clk),
    .res         (res),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ch      (cmd_ch),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_interval(cmd_interval),
    .cmd_abort   (cmd_abort),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple PWM register file answering the bus (read data one cycle later).
  assign hw_idx = 3'((bus_addr - 32'd4) / 32'd12);
  always @(posedge clk) begin
    if (bus_wr) pwm_hw[hw_idx] <= bus_data;
    bus_rdata <= bus_rd ? pwm_hw[hw_idx] : 32'd0;
  end

  function automatic logic [31:0] cur_of(input int ch);
`ifdef SEQ_READBACK_EN
    return pwm_m[ch];
`else
    return shadow_m[ch];
`endif
  endfunction

  // Issue one move and check every write, the done pulse and bus protocol.
  task automatic run_cmd(input int ch, input logic [31:0] tgt, input logic [15:0] stp,
                         input logic [23:0] itv, input int abort_after, input string name);
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr, exp_v;
    longint cur, nx, t;
    int period, acc, n, wr_cnt, done_cnt, done_at, exp_done, waited;
    bit aborting, proto_bad;
    period   = ((itv == 24'd0) ? 1 : int'(itv)) + 2;
    exp_addr = 32'(ch) * 32'd12 + 32'd4;
    cur = longint'(cur_of(ch));
    t   = longint'(tgt);
    while (cur != t) begin
      if (stp == 16'd0) nx = t;
      else if (t > cur) begin nx = cur + longint'(stp); if (nx > t) nx = t; end
      else begin nx = cur - longint'(stp); if (nx < t) nx = t; end
      exp_q.push_back(nx[31:0]);
      cur = nx;
    end
    aborting = (abort_after > 0) && (abort_after < exp_q.size());
    if (aborting) while (exp_q.size() > abort_after) void'(exp_q.pop_back());
    n = exp_q.size();

    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL %s ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    cmd_ch = 3'(ch); cmd_target = tgt; cmd_step = stp; cmd_interval = itv;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready=%b busy=%b required ready=0 busy=1", name, cmd_ready, busy);
    end
    exp_done = acc + RB_EXTRA + ((n == 0) ? 1 : n * period + (aborting ? 2 : 1));

    wr_cnt = 0; done_cnt = 0; done_at = -1; proto_bad = 1'b0;
    while (cyc < exp_done + 2 && cyc < acc + 5000) begin
      @(negedge clk);
      cmd_abort = 1'b0;
      if (bus_wr) begin
        exp_v = (wr_cnt < n) ? exp_q[wr_cnt] : 32'd0;
        checks++;
        if (wr_cnt >= n || cyc != acc + RB_EXTRA + (wr_cnt + 1) * period ||
            bus_addr !== exp_addr || bus_data !== exp_v) begin
          errors++;
          $display("FAIL %s write%0d: cyc=+%0d addr=%h data=%0d required cyc=+%0d addr=%h data=%0d (of %0d)",
                   name, wr_cnt, cyc - acc, bus_addr, bus_data,
                   RB_EXTRA + (wr_cnt + 1) * period, exp_addr, exp_v, n);
        end
        wr_cnt++;
        if (aborting && wr_cnt == abort_after) cmd_abort = 1'b1;
      end
      if (done) begin done_cnt++; done_at = cyc; end
      if (bus_wr && bus_rd) proto_bad = 1'b1;
      if (!bus_wr && !bus_rd && (bus_addr !== 32'd0 || bus_data !== 32'd0)) proto_bad = 1'b1;
      if (bus_rd && !(RB_EXTRA != 0 && cyc == acc && bus_addr == exp_addr)) proto_bad = 1'b1;
      if (busy !== (cyc < exp_done)) proto_bad = 1'b1;
    end
    checks++;
    if (wr_cnt != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_cnt, n);
    end
    checks++;
    if (done_cnt != 1 || done_at != exp_done) begin
      errors++;
      $display("FAIL %s done: pulses=%0d at +%0d required 1 at +%0d", name, done_cnt,
               done_at - acc, exp_done - acc);
    end
    checks++;
    if (proto_bad) begin
      errors++;
      $display("FAIL %s protocol: strobe/addr/data/busy rule broken, got 1 required 0", name);
    end
    if (n > 0) begin
      shadow_m[ch] = exp_q[n - 1];
      pwm_m[ch]    = exp_q[n - 1];
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cmd_ready, bus_wr, bus_rd, busy, done} !== 5'b0 || bus_addr !== 32'd0 || bus_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b wr=%b rd=%b busy=%b done=%b addr=%h data=%h required all 0",
               cmd_ready, bus_wr, bus_rd, busy, done, bus_addr, bus_data);
    end
    res = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_ramp_up();
    run_cmd(2, 32'd75300, 16'd100, 24'd4, 0, "ramp_up");
  endtask

  task automatic test_clamp_down();
    run_cmd(0, 32'd74950, 16'd100, 24'd0, 0, "clamp_down");
  endtask

  task automatic test_jump();
    run_cmd(7, 32'd90000, 16'd0, 24'd3, 0, "jump");
  endtask

  task automatic test_equal();
    run_cmd(5, cur_of(5), 16'd10, 24'd2, 0, "equal");
  endtask

  task automatic test_abort();
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    cmd_abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || bus_wr) bad = 1'b1;
    end
    cmd_abort = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_idle: activity=1 required 0");
    end
    run_cmd(1, 32'd76000, 16'd100, 24'd2, 2, "abort_mid");
    run_cmd(1, 32'd75000, 16'd300, 24'd1, 0, "after_abort");
  endtask

  task automatic test_boundaries();
    run_cmd(3, 32'd0, 16'hFFFF, 24'd0, 0, "down_to_zero");
    run_cmd(6, 32'hFFFF_FF00, 16'd0, 24'd0, 0, "jump_high");
    run_cmd(6, 32'hFFFF_FFFF, 16'hFFFF, 24'd1, 0, "up_to_max");
  endtask

  task automatic test_reset_mid_wait();
    bit bad;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
    cmd_ch = 3'd4; cmd_target = cur_of(4) + 32'd5000; cmd_step = 16'd100; cmd_interval = 24'd40;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 res = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, bus_wr, bus_rd, busy, done} !== 5'b0 || bus_addr !== 32'd0 || bus_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: ready=%b wr=%b rd=%b busy=%b done=%b required all 0",
               cmd_ready, bus_wr, bus_rd, busy, done);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b busy=%b required 0 0", cmd_ready, busy);
    end
    res = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b required 1", cmd_ready);
    end
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus_wr || done || busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_abandon: activity=1 required 0");
    end
    for (int i = 0; i < 8; i++) shadow_m[i] = DUTY_RST;
    run_cmd(4, DUTY_RST, 16'd0, 24'd0, 0, "post_reset_equal");
    run_cmd(4, 32'd75030, 16'd10, 24'd1, 0, "post_reset_ramp");
  endtask

  task automatic test_random();
    int ch, sel, ab;
    longint base, tg;
    logic [15:0] stp;
    logic [23:0] itv;
    for (int k = 0; k < 12; k++) begin
      ch   = int'($urandom_range(0, 7));
      base = longint'(cur_of(ch));
      sel  = int'($urandom_range(0, 5));
      if (sel == 0) tg = base;
      else if (sel[0]) tg = base + longint'($urandom_range(1, 3000));
      else tg = base - longint'($urandom_range(1, 3000));
      if (tg < 0) tg = 0;
      if (tg > 64'h0000_0000_FFFF_FFFF) tg = 64'h0000_0000_FFFF_FFFF;
      stp = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(60, 500));
      itv = 24'($urandom_range(0, 5));
      ab  = ($urandom_range(0, 4) == 0) ? 2 : 0;
      run_cmd(ch, tg[31:0], stp, itv, ab, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(0, cur_of(0) + 32'd250, 16'd125, 24'd0, 0, "b2b_first");
    run_cmd(0, cur_of(0) - 32'd100, 16'd0, 24'd2, 0, "b2b_second");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      shadow_m[i] = DUTY_RST;
      pwm_m[i]    = DUTY_RST;
    end
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_jump();
    test_equal();
    test_abort();
    test_boundaries();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
